// File: rtl/gmem_pkg.sv
// Shared types and constants for the global data-memory responder.
package gmem_pkg;

    // Per-channel request life cycle.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        BUSY = 3'd2,
        RESP = 3'd3,
        DROP = 3'd4
    } chan_state_t;

    // Kind of access latched when a channel leaves IDLE.
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } req_kind_t;

    localparam int LAT_CNT_BITS = 4;
    // One extra bit keeps LATENCY-1 plus up to 3 jitter cycles from wrapping.
    localparam int CNT_W        = LAT_CNT_BITS + 1;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Next state of the jitter LFSR: shift left, feed back the tap parity.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/gmem_responder_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req_i,
    input  logic         accept_i,
    output logic [N-1:0] grant_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [N-1:0]  grant_s;

    // Pick the first requester at or after the pointer, wrapping around.
    always_comb begin
        int   idx;
        logic found;
        grant_s = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && accept_i && req_i[idx]) begin
                grant_s[idx] = 1'b1;
                ptr_d        = PW'((idx + 1) % N);
                found        = 1'b1;
            end else begin
                found = found;
            end
        end
    end

    assign grant_o = grant_s;

    // Pointer moves only when a grant is actually issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/gmem_responder.sv
// Multi-channel global memory responder: per-channel request FSMs share one
// single-port storage array through a round-robin arbiter and answer each
// access with a one-cycle ready pulse a fixed latency after its grant.
// Optional build macro GMEM_RESP_JITTER_EN adds 0..3 random extra cycles.
module gmem_responder
    import gmem_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = 2
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]                mem_read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
    input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
    output logic [NUM_CHANNELS-1:0]                mem_write_ready
);
    chan_state_t                            state_q  [NUM_CHANNELS];
    req_kind_t                              kind_q   [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]                   addr_q   [NUM_CHANNELS];
    logic [DATA_BITS-1:0]                   wdata_q  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]                   sample_q [NUM_CHANNELS];
    logic [CNT_W-1:0]                       cnt_q    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]                rd_ready_q;
    logic [NUM_CHANNELS-1:0]                wr_ready_q;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] rd_data_q;
    logic [DATA_BITS-1:0]                   mem_q    [2**ADDR_BITS];

    logic [NUM_CHANNELS-1:0] req_s;
    logic [NUM_CHANNELS-1:0] grant_s;
    logic                    g_we_s;
    logic [ADDR_BITS-1:0]    g_addr_s;
    logic [DATA_BITS-1:0]    g_wdata_s;
    logic [CNT_W-1:0]        lat_load_s;

`ifdef GMEM_RESP_JITTER_EN
    logic [7:0] lfsr_q;

    // Free-running LFSR supplying the per-access extra wait cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign lat_load_s = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
`else
    assign lat_load_s = CNT_W'(LATENCY - 1);
`endif

    // Channels waiting in REQ compete for the storage port.
    always_comb begin
        req_s = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            req_s[i] = (state_q[i] == REQ);
        end
    end

    rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_i    (req_s),
        .accept_i (1'b1),
        .grant_o  (grant_s)
    );

    // Route the granted channel's latched write onto the storage port.
    always_comb begin
        g_we_s    = 1'b0;
        g_addr_s  = '0;
        g_wdata_s = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (grant_s[i]) begin
                g_we_s    = (kind_q[i] == WRITE);
                g_addr_s  = addr_q[i];
                g_wdata_s = wdata_q[i];
            end else begin
                g_we_s = g_we_s;
            end
        end
    end

    // Storage is deliberately not reset; a granted write lands at the grant edge.
    always_ff @(posedge clk) begin
        if (g_we_s) begin
            mem_q[g_addr_s] <= g_wdata_s;
        end
    end

    // Per-channel request FSMs with registered ready pulses and read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ready_q <= '0;
            wr_ready_q <= '0;
            rd_data_q  <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i]  <= IDLE;
                kind_q[i]   <= READ;
                addr_q[i]   <= '0;
                wdata_q[i]  <= '0;
                sample_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                rd_ready_q[i] <= 1'b0;
                wr_ready_q[i] <= 1'b0;
                case (state_q[i])
                    IDLE: begin
                        // A simultaneous read stays pending until the write retires.
                        if (mem_write_valid[i]) begin
                            kind_q[i]  <= WRITE;
                            addr_q[i]  <= mem_write_address[i];
                            wdata_q[i] <= mem_write_data[i];
                            state_q[i] <= REQ;
                        end else if (mem_read_valid[i]) begin
                            kind_q[i]  <= READ;
                            addr_q[i]  <= mem_read_address[i];
                            state_q[i] <= REQ;
                        end else begin
                            state_q[i] <= IDLE;
                        end
                    end
                    REQ: begin
                        if (grant_s[i]) begin
                            sample_q[i] <= mem_q[addr_q[i]];
                            cnt_q[i]    <= lat_load_s;
                            if (lat_load_s == '0) begin
                                // Single-cycle latency: respond right after the grant.
                                state_q[i] <= RESP;
                                if (kind_q[i] == READ) begin
                                    rd_ready_q[i] <= 1'b1;
                                    rd_data_q[i]  <= mem_q[addr_q[i]];
                                end else begin
                                    wr_ready_q[i] <= 1'b1;
                                end
                            end else begin
                                state_q[i] <= BUSY;
                            end
                        end else begin
                            state_q[i] <= REQ;
                        end
                    end
                    BUSY: begin
                        if (cnt_q[i] == CNT_W'(1)) begin
                            cnt_q[i]   <= '0;
                            state_q[i] <= RESP;
                            if (kind_q[i] == READ) begin
                                rd_ready_q[i] <= 1'b1;
                                rd_data_q[i]  <= sample_q[i];
                            end else begin
                                wr_ready_q[i] <= 1'b1;
                            end
                        end else begin
                            cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                        end
                    end
                    RESP: begin
                        state_q[i] <= DROP;
                    end
                    DROP: begin
                        // Wait for the served valid to fall so a held valid is not re-served.
                        if (kind_q[i] == WRITE ? !mem_write_valid[i] : !mem_read_valid[i]) begin
                            state_q[i] <= IDLE;
                        end else begin
                            state_q[i] <= DROP;
                        end
                    end
                    default: begin
                        state_q[i] <= IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_read_ready  = rd_ready_q;
    assign mem_write_ready = wr_ready_q;
    assign mem_read_data   = rd_data_q;

endmodule

// File: tb/tb_gmem_responder.sv
// Directed bench for gmem_responder with a read-data scoreboard.
module tb_gmem_responder;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NC = 4;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NC-1:0]         rv, wv, rr, wr;
    logic [NC-1:0][AW-1:0] ra, wa;
    logic [NC-1:0][DW-1:0] wd, rd;

    always #5 clk = ~clk;

    gmem_responder #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CHANNELS(NC), .LATENCY(2)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .mem_read_valid    (rv),
        .mem_read_address  (ra),
        .mem_read_ready    (rr),
        .mem_read_data     (rd),
        .mem_write_valid   (wv),
        .mem_write_address (wa),
        .mem_write_data    (wd),
        .mem_write_ready   (wr)
    );

    typedef struct {
        int         ch;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    int         pass_cnt = 0;
    int         fail_cnt = 0;
    int         chk_cnt  = 0;
    int         cyc_n    = 0;
    int         rd_cycle [NC];
    int         wr_cycle [NC];
    int         rd_pulses[NC];
    int         wr_pulses[NC];
    logic [NC-1:0] last_rd, last_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ev);
        chk_cnt++;
        assert (obs === ev) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, ev);
        end
    endtask

    // Observe the current cycle at the falling edge, then move to the next cycle.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        last_rd = rr;
        last_wr = wr;
        for (int c = 0; c < NC; c++) begin
            if (rr[c]) begin
                rd_cycle[c] = cyc_n;
                rd_pulses[c]++;
                if (sb_q.size() == 0) begin
                    chk($sformatf("rd_unexpected_ch%0d", c), 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("rd_chan_ch%0d", c), c, e.ch);
                    chk($sformatf("rd_data_ch%0d", c), {24'd0, rd[c]}, {24'd0, e.data});
                end
            end
            if (wr[c]) begin
                wr_cycle[c] = cyc_n;
                wr_pulses[c]++;
            end
        end
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(input int ch, input string tag);
        int n = 0;
        do begin cyc(); n++; end while (!last_rd[ch] && n < 40);
        if (!last_rd[ch]) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_wr(input int ch, input string tag);
        int n = 0;
        do begin cyc(); n++; end while (!last_wr[ch] && n < 40);
        if (!last_wr[ch]) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Lone read: latency 3 cycles from raising valid (latch, grant, +2).
    task automatic read_req(input int ch, input logic [7:0] addr, input logic [7:0] ev);
        int t;
        sb_q.push_back('{ch, ev});
        ra[ch] = addr;
        rv[ch] = 1'b1;
        t = cyc_n;
        wait_rd(ch, "rd");
        chk($sformatf("rd_lat_ch%0d", ch), rd_cycle[ch] - t, 32'd3);
        rv[ch] = 1'b0;
        cyc();
        chk("rd_pulse_width", {31'd0, last_rd[ch]}, 32'd0);
    endtask

    task automatic write_req(input int ch, input logic [7:0] addr, input logic [7:0] data);
        int t;
        wa[ch] = addr;
        wd[ch] = data;
        wv[ch] = 1'b1;
        t = cyc_n;
        wait_wr(ch, "wr");
        chk($sformatf("wr_lat_ch%0d", ch), wr_cycle[ch] - t, 32'd3);
        wv[ch] = 1'b0;
        cyc();
        chk("wr_pulse_width", {31'd0, last_wr[ch]}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n, base;
        int bw0, bw1;
        logic [NC-1:0] got;

        for (int c = 0; c < NC; c++) begin
            rd_cycle[c] = 0; wr_cycle[c] = 0; rd_pulses[c] = 0; wr_pulses[c] = 0;
        end
        reset_n = 1'b0;
        rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
        repeat (2) @(negedge clk);
        chk("reset_rd_ready", {28'd0, rr}, 32'd0);
        chk("reset_wr_ready", {28'd0, wr}, 32'd0);
        chk("reset_rd_data", rd, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc();

        // Single read of a preloaded word, then an immediate second read.
        write_req(0, 8'h10, 8'h5A);
        read_req(0, 8'h10, 8'h5A);
        read_req(0, 8'h10, 8'h5A);

        // Write then read on channel 1.
        write_req(1, 8'h20, 8'h3C);
        read_req(1, 8'h20, 8'h3C);

        // Preload on all channels; last grant on ch3 brings the pointer back to 0.
        for (int c = 0; c < NC; c++) write_req(c, 8'h30 + 8'(c), 8'hC0 + 8'(c));

        // Contention: four reads in the same cycle.
        t = cyc_n;
        for (int c = 0; c < NC; c++) begin
            ra[c] = 8'h30 + 8'(c);
            rv[c] = 1'b1;
            sb_q.push_back('{c, 8'hC0 + 8'(c)});
        end
        got = '0;
        n = 0;
        while (got != 4'hF && n < 40) begin
            cyc();
            n++;
            got = got | last_rd;
        end
        chk("contention_all_served", {28'd0, got}, 32'h0000000F);
        for (int c = 0; c < NC; c++) chk($sformatf("contention_ready_ch%0d", c), rd_cycle[c] - t, 3 + c);
        rv = '0;
        cyc();

        // Held valid: one pulse only; drop and re-raise gives a fresh access.
        base = rd_pulses[2];
        sb_q.push_back('{2, 8'hC2});
        ra[2] = 8'h32;
        rv[2] = 1'b1;
        wait_rd(2, "held_first");
        repeat (5) cyc();
        chk("held_single_pulse", rd_pulses[2] - base, 32'd1);
        rv[2] = 1'b0;
        cyc();
        sb_q.push_back('{2, 8'hC2});
        rv[2] = 1'b1;
        wait_rd(2, "held_second");
        chk("held_second_pulse", rd_pulses[2] - base, 32'd2);
        rv[2] = 1'b0;
        cyc();

        // Write wins over a simultaneous read; the read follows and sees it.
        wa[3] = 8'h50; wd[3] = 8'h77; ra[3] = 8'h50;
        sb_q.push_back('{3, 8'h77});
        wv[3] = 1'b1;
        rv[3] = 1'b1;
        wait_wr(3, "both_wr");
        wv[3] = 1'b0;
        wait_rd(3, "both_rd");
        chk("write_before_read", {31'd0, wr_cycle[3] < rd_cycle[3]}, 32'd1);
        rv[3] = 1'b0;
        cyc();

        write_req(2, 8'h61, 8'h11);

        // Reset while ch0's write is granted and ch1's is still waiting.
        bw0 = wr_pulses[0];
        bw1 = wr_pulses[1];
        wa[0] = 8'h60; wd[0] = 8'h99; wv[0] = 1'b1;
        cyc();
        wa[1] = 8'h61; wd[1] = 8'h44; wv[1] = 1'b1;
        cyc();
        reset_n = 1'b0;
        cyc();
        chk("midrst_rd_ready", {28'd0, last_rd}, 32'd0);
        chk("midrst_wr_ready", {28'd0, last_wr}, 32'd0);
        chk("midrst_rd_data", rd, 32'd0);
        wv = '0;
        cyc();
        reset_n = 1'b1;
        repeat (4) cyc();
        chk("midrst_no_wr_pulse", (wr_pulses[0] - bw0) + (wr_pulses[1] - bw1), 32'd0);

        // Same-address write race with the pointer at 0.
        wa[0] = 8'h40; wd[0] = 8'hAA;
        wa[1] = 8'h40; wd[1] = 8'hBB;
        wv[0] = 1'b1; wv[1] = 1'b1;
        got = '0;
        n = 0;
        while (got[1:0] != 2'b11 && n < 40) begin
            cyc();
            n++;
            got = got | last_wr;
        end
        chk("race_both_served", {30'd0, got[1:0]}, 32'd3);
        chk("race_order", wr_cycle[1] - wr_cycle[0], 32'd1);
        wv = '0;
        cyc();

        read_req(0, 8'h40, 8'hBB);
        read_req(1, 8'h60, 8'h99);
        read_req(2, 8'h61, 8'h11);

        // Pointer now at 3: ch3 write is granted before ch0's read of the same address.
        wa[3] = 8'h70; wd[3] = 8'hD1; wv[3] = 1'b1;
        ra[0] = 8'h70; rv[0] = 1'b1;
        sb_q.push_back('{0, 8'hD1});
        got = '0;
        n = 0;
        while (!(got[0] && last_wr[3] === 1'b0 && wr_cycle[3] > 0 && got[3]) && n < 40) begin
            cyc();
            n++;
            got[0] = got[0] | last_rd[0];
            got[3] = got[3] | last_wr[3];
        end
        chk("raw_order", rd_cycle[0] - wr_cycle[3], 32'd1);
        wv = '0;
        rv = '0;
        cyc();
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/gmem_responder.md
Name: gmem_responder

Overview:
- Multi-channel global data-memory responder: the memory end of the channel interface that the data cache/memory controller drives.
- Accepts per-channel read/write requests, serializes them onto one single-port storage array with a round-robin arbiter, and returns a one-cycle ready pulse after a fixed access latency.
- Used as the simulation/FPGA-resident global memory behind the data cache.

Parameters:
- ADDR_BITS, 8, address width; storage depth is 2**ADDR_BITS words.
- DATA_BITS, 8, word width.
- NUM_CHANNELS, 4, number of request channels.
- LATENCY, 2, cycles from grant to ready pulse; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- mem_read_valid  in  NUM_CHANNELS  per-channel read request, held until the ready pulse is seen.
- mem_read_address  in  [ADDR_BITS-1:0] x NUM_CHANNELS  read address, stable while valid.
- mem_read_ready  out  NUM_CHANNELS  one-cycle read-done pulse.
- mem_read_data  out  [DATA_BITS-1:0] x NUM_CHANNELS  read data, valid in the ready cycle and held until the next read response on that channel.
- mem_write_valid  in  NUM_CHANNELS  per-channel write request.
- mem_write_address  in  [ADDR_BITS-1:0] x NUM_CHANNELS  write address.
- mem_write_data  in  [DATA_BITS-1:0] x NUM_CHANNELS  write data.
- mem_write_ready  out  NUM_CHANNELS  one-cycle write-done pulse.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0, all channel FSMs IDLE, round-robin pointer 0, latency counters 0. Storage contents are not cleared.
- Per-channel FSM states: IDLE, REQ, BUSY, RESP, DROP.
- IDLE -> REQ: when read_valid or write_valid is high. Latch kind (write wins if both are high; the read stays pending and is served after DROP), address and write data.
- REQ: wait for a grant. One grant per cycle across all channels. Round-robin order starts at the channel after the last granted one.
- On grant, REQ -> BUSY:
  - Write: storage updated at the grant edge.
  - Read: storage sampled at the grant edge into a per-channel data register.
  - Counter loads LATENCY-1.
- BUSY: decrement the counter each cycle. At 0, go to RESP.
- Latency rule: with LATENCY=1, ready asserts the cycle immediately after grant. In general, ready asserts exactly LATENCY cycles after the grant edge.
- RESP: assert the ready bit of the matching kind (read: drive mem_read_data) for exactly one cycle, then go to DROP.
- DROP: wait until the valid bit of the served kind is low, then go to IDLE.
  - A new request is accepted no earlier than the cycle after valid is seen low.
  - This prevents double-serving a still-held valid. An initiator that lowers valid one cycle after ready and re-raises it the next cycle gets a fresh access.
- Ordering: the memory is single-port and accesses are serialized in grant order.
  - Same-address write and read on different channels: the later grant observes the earlier write.
  - Two writes to the same address: the later grant's data persists.
- A request's address and data are ignored after the IDLE->REQ latch. Valid dropping before ready (protocol violation) does not abort the access; the ready pulse still occurs.
- Worst-case service time for one channel: NUM_CHANNELS-1 grant waits + LATENCY cycles.
- Reset mid-operation: in-flight accesses are discarded. A write already granted has updated storage; an ungranted write has not.

Optional Feature:
- Macro: GMEM_RESP_JITTER_EN.
- Defined:
  - Adds an 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5, advances every cycle).
  - On grant, the counter loads LATENCY-1 + lfsr[1:0], giving 0..3 extra cycles per access. This stress-tests initiator wait states.
  - Ordering and handshake rules are unchanged.
- Undefined: fixed latency exactly LATENCY; no LFSR logic.

Decomposition:
- Package gmem_pkg:
  - chan_state_t enum (IDLE, REQ, BUSY, RESP, DROP).
  - req_kind_t (READ, WRITE).
  - LAT_CNT_BITS=4 constant.
  - LFSR seed/taps constants.
- Sub-module rr_arbiter (parameter N):
  - Inputs: request vector, grant-accept.
  - Output: one-hot grant.
  - The internal last-grant pointer advances only when a grant is issued.

Test Plan:
- Single read, LATENCY=2, addr 8'h10 preloaded 8'h5A: valid at cycle 0, granted cycle 1 -> read_ready[0] high cycle 3 only, data 8'h5A; valid low cycle 4 -> IDLE at cycle 5.
- Write then read, channel 1: write 8'h3C to 8'h20, wait for ready, drop valid; read 8'h20 -> data 8'h3C.
- Contention: all 4 channels raise read valid in the same cycle, pointer at 0 -> grants in order ch0,1,2,3 on consecutive cycles; ready pulses on consecutive cycles, each LATENCY after its grant.
- Held valid: keep read_valid[2] high 5 cycles after ready -> exactly one ready pulse, no second access; drop and re-raise -> second pulse.
- Reset mid-op: assert reset_n low while ch0 is BUSY -> all ready 0 immediately; after release, a new request completes normally; a granted pre-reset write is visible.
- Same-address race: ch0 write 8'hAA and ch1 write 8'hBB to 8'h40, same cycle, pointer 0 -> subsequent read returns 8'hBB.
